// File: rtl/instr_rom_loader.sv
// instr_rom_loader: Hack instruction memory with a byte-stream bootloader.
//
// Holds DEPTH words of DATA_W bits. The CPU reads through a one-cycle
// registered, read-first port that works in every state. A program image is
// written as LEN_HI, LEN_LO (word count N, big-endian) followed by N words,
// each sent HI byte then LO byte, one byte per ld_valid && ld_ready transfer.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset (memory contents are kept)
//   address      CPU fetch address
//   out          registered instruction word, mem[address] one cycle later
//   ld_start     begin a load, sampled only while idle
//   ld_byte      loader data byte
//   ld_valid     ld_byte is valid
//   ld_ready     block accepts ld_byte this cycle
//   cpu_hold     high while an image is being received; drives CPU reset
//   load_done    one-cycle pulse after the last word has been written
//   load_err     sticky: requested length exceeded DEPTH
//   words_loaded words written by the current or last load
module instr_rom_loader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  input  logic              ld_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StDone
  } state_e;

  state_e            state_q;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [7:0]        hi_q;
  logic [ADDR_W:0]   wp_q;
  logic              load_err_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic        xfer;
  logic        mem_we;
  logic [15:0] len_full;

  // Ready/hold are pure decodes of the registered state, so they change only on
  // clock edges and drop the cycle after a reset edge.
  assign ld_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                     (state_q == StDataHi) || (state_q == StDataLo);
  assign cpu_hold  = ld_ready;
  assign load_done = (state_q == StDone);
  assign load_err  = load_err_q;
  // The write pointer and the loaded-word count move in lockstep.
  assign words_loaded = wp_q;

  assign xfer     = ld_valid && ld_ready;
  assign mem_we   = xfer && (state_q == StDataLo);
  assign len_full = {len_hi_q, ld_byte};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_hi_q   <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      wp_q       <= '0;
      load_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ld_start) begin
            state_q    <= StLenHi;
            load_err_q <= 1'b0;
            wp_q       <= '0;
          end
        end
        StLenHi: begin
          if (ld_valid) begin
            len_hi_q <= ld_byte;
            state_q  <= StLenLo;
          end
        end
        StLenLo: begin
          if (ld_valid) begin
            len_q <= len_full;
            if (len_full == 16'd0) begin
              state_q <= StDone;
            end else if (32'(len_full) > DEPTH) begin
              // Oversized image: reject before any memory write.
              state_q    <= StIdle;
              load_err_q <= 1'b1;
            end else begin
              state_q <= StDataHi;
            end
          end
        end
        StDataHi: begin
          if (ld_valid) begin
            hi_q    <= ld_byte;
            state_q <= StDataLo;
          end
        end
        StDataLo: begin
          if (ld_valid) begin
            wp_q <= wp_q + 1'b1;
            if (32'(wp_q) + 32'd1 == 32'(len_q)) begin
              state_q <= StDone;
            end else begin
              state_q <= StDataHi;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory array: never reset, so words beyond N survive a load or a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wp_q[MemAw-1:0]] <= DATA_W'({hi_q, ld_byte});
    end
  end

  // Read-first: a same-edge write to the fetched address returns the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (32'(address) < DEPTH) begin
      out <= mem[address[MemAw-1:0]];
    end else begin
      out <= '0;
    end
  end

endmodule

// File: tb/tb_instr_rom_loader.sv
module tb_instr_rom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] address;
  logic [15:0] out;
  logic        ld_start;
  logic [7:0]  ld_byte;
  logic        ld_valid;
  logic        ld_ready;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  int vectors     = 0;
  int miscompares = 0;
  int rdy_cnt     = 0;
  int done_cnt    = 0;

  // Hack "add 2+3" program: @2, D=A, @3, D=D+A, @0, M=D, @6, 0;JMP
  logic [15:0] prog [8] = '{16'h0002, 16'hEC10, 16'h0003, 16'hE090,
                            16'h0000, 16'hE308, 16'h0006, 16'hEA87};

  always #5 clk = ~clk;

  instr_rom_loader dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .out          (out),
    .ld_start     (ld_start),
    .ld_byte      (ld_byte),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // Edge counters: sample the pre-edge value of each output.
  always @(posedge clk) begin
    if (ld_ready) rdy_cnt <= rdy_cnt + 1;
    if (load_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    ld_byte  = b;
    ld_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [14:0] a, input logic [15:0] exp);
    address = a;
    @(negedge clk);
    check(tag, 32'(out), 32'(exp));
  endtask

  initial begin
    int d0;
    int r0;
    logic hold_ok;
    logic [7:0] img [18];

    reset    = 1'b1;
    address  = '0;
    ld_start = 1'b0;
    ld_byte  = '0;
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'h0);
    check("rst_ready", 32'(ld_ready), 32'h0);
    check("rst_hold", 32'(cpu_hold), 32'h0);
    check("rst_done", 32'(load_done), 32'h0);
    check("rst_err", 32'(load_err), 32'h0);
    check("rst_words", 32'(words_loaded), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back N=8 stream.
    r0 = rdy_cnt;
    d0 = done_cnt;
    start_load();
    check("b2b_hold_start", 32'(cpu_hold), 32'h1);
    send(8'h00);
    send(8'h08);
    for (int i = 0; i < 8; i++) begin
      send(prog[i][15:8]);
      send(prog[i][7:0]);
    end
    ld_valid = 1'b0;
    check("b2b_done_pulse", 32'(load_done), 32'h1);
    check("b2b_ready_done", 32'(ld_ready), 32'h0);
    check("b2b_words", 32'(words_loaded), 32'd8);
    @(negedge clk);
    check("b2b_done_drop", 32'(load_done), 32'h0);
    check("b2b_ready_cycles", 32'(rdy_cnt - r0), 32'd18);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      read_check("b2b_mem", 15'(i), prog[i]);
    end

    // Same image with ld_valid toggling; 0xFF filler bytes must be dropped.
    img[0] = 8'h00;
    img[1] = 8'h08;
    for (int i = 0; i < 8; i++) begin
      img[2 + 2 * i] = prog[i][15:8];
      img[3 + 2 * i] = prog[i][7:0];
    end
    d0 = done_cnt;
    hold_ok = 1'b1;
    start_load();
    for (int k = 0; k < 18; k++) begin
      send(img[k]);
      if (k < 17) hold_ok = hold_ok & cpu_hold;
      else check("tog_done_pulse", 32'(load_done), 32'h1);
      ld_valid = 1'b0;
      ld_byte  = 8'hFF;
      @(negedge clk);
      if (k < 17) hold_ok = hold_ok & cpu_hold;
    end
    check("tog_hold", 32'(hold_ok), 32'h1);
    check("tog_words", 32'(words_loaded), 32'd8);
    check("tog_done_count", 32'(done_cnt - d0), 32'd1);
    read_check("tog_mem1", 15'd1, 16'hEC10);
    read_check("tog_mem5", 15'd5, 16'hE308);
    read_check("tog_mem7", 15'd7, 16'hEA87);

    // N=0: straight to DONE.
    d0 = done_cnt;
    start_load();
    send(8'h00);
    send(8'h00);
    ld_valid = 1'b0;
    check("n0_done_pulse", 32'(load_done), 32'h1);
    check("n0_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    check("n0_done_count", 32'(done_cnt - d0), 32'd1);
    read_check("n0_mem0", 15'd0, 16'h0002);

    // N=DEPTH+1: rejected with sticky error.
    d0 = done_cnt;
    start_load();
    send(8'h80);
    send(8'h01);
    ld_valid = 1'b0;
    check("ovf_err", 32'(load_err), 32'h1);
    check("ovf_ready", 32'(ld_ready), 32'h0);
    check("ovf_hold", 32'(cpu_hold), 32'h0);
    check("ovf_done", 32'(load_done), 32'h0);
    repeat (2) @(negedge clk);
    check("ovf_err_sticky", 32'(load_err), 32'h1);
    check("ovf_done_count", 32'(done_cnt - d0), 32'd0);
    read_check("ovf_mem0", 15'd0, 16'h0002);
    start_load();
    check("ovf_err_clear", 32'(load_err), 32'h0);
    check("ovf_restart_ready", 32'(ld_ready), 32'h1);

    // Reset after 3 of 8 words.
    send(8'h00);
    send(8'h08);
    send(8'hA0); send(8'h01);
    send(8'hA0); send(8'h02);
    send(8'hA0); send(8'h03);
    send(8'hA0);
    ld_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hold", 32'(cpu_hold), 32'h0);
    check("abort_ready", 32'(ld_ready), 32'h0);
    check("abort_words", 32'(words_loaded), 32'h0);
    read_check("abort_mem0", 15'd0, 16'hA001);
    read_check("abort_mem1", 15'd1, 16'hA002);
    read_check("abort_mem2", 15'd2, 16'hA003);
    for (int i = 3; i < 8; i++) begin
      read_check("abort_mem_old", 15'(i), prog[i]);
    end
    check("abort_done_count", 32'(done_cnt - d0), 32'd0);

    // Read-first collision at wp, with ld_start pulsed mid-load.
    d0 = done_cnt;
    start_load();
    send(8'h00);
    send(8'h02);
    send(8'h11);
    address  = 15'd0;
    ld_start = 1'b1;
    send(8'h11);
    check("rfw_old", 32'(out), 32'hA001);
    check("rfw_words1", 32'(words_loaded), 32'd1);
    send(8'h22);
    check("rfw_new", 32'(out), 32'h1111);
    address = 15'd1;
    send(8'h22);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("rfw_old1", 32'(out), 32'hA002);
    check("rfw_done_pulse", 32'(load_done), 32'h1);
    check("rfw_words2", 32'(words_loaded), 32'd2);
    read_check("rfw_new1", 15'd1, 16'h2222);
    check("rfw_idle_ready", 32'(ld_ready), 32'h0);
    check("rfw_done_count", 32'(done_cnt - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
